ysyx_23060278_wb_arb: RTL and testbench
=======================================

// Module: ysyx_23060278_wb_arb
// PURPOSE
//  Write-back arbiter and scoreboard for the NPC integer register file.
//  Shares the single GPR write port between ALU results and LSU load data, using round-robin priority.
//  Tracks registers with pending writes and holds back issue on RAW and WAW hazards.
//  Sits between EXU/LSU and the GPR write port; drives gpr_wen/gpr_rd/gpr_wdata.
// PARAMETERS
//  XLEN   32  data width
//  NREG   32  architectural register count; x0 hardwired zero
//  AW     5   register index width, equal to $clog2(NREG)
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous reset, active-high
//  iss_valid    in   1     IDU presents an instruction for issue
//  iss_ready    out  1     issue accepted this cycle (no hazard)
//  iss_wr       in   1     instruction writes rd
//  iss_rd       in   AW    destination index
//  iss_rs1/2    in   AW    source indices
//  iss_use_rs1/2 in  1     source actually read
//  alu_valid    in   1     ALU write-back request
//  alu_ready    out  1     ALU request granted
//  alu_rd       in   AW    ALU destination
//  alu_data     in   XLEN  ALU result
//  lsu_valid    in   1     LSU write-back request
//  lsu_ready    out  1     LSU request granted
//  lsu_rd       in   AW    LSU destination
//  lsu_data     in   XLEN  LSU load data
//  gpr_wen      out  1     GPR write enable
//  gpr_rd       out  AW    GPR write index
//  gpr_wdata    out  XLEN  GPR write data
//  fwd_hit1/2   out  1     rs1/rs2 matched the write in flight (forwarding only)
//  fwd_data     out  XLEN  forwarded value; equals gpr_wdata (forwarding only)
//  err_wb       out  1     sticky: write-back to a non-busy rd != 0
// BEHAVIOUR
//  Reset values
//   - gpr_wen=0, gpr_rd=0, gpr_wdata=0, err_wb=0.
//   - All busy bits cleared.
//   - last_grant=LSU, so the first conflict goes to ALU.
//  Handshake: valid/ready
//   - Requester holds valid and payload until ready.
//   - A transfer completes when valid & ready are both high.
//  Arbitration (combinational, every cycle)
//   - If only one requester is valid, it is granted.
//   - If both are valid, the requester not equal to last_grant is granted.
//   - last_grant updates on every transfer.
//  Output stage
//   - The accepted request is registered, so gpr_wen is high for exactly one cycle, on the cycle after the transfer.
//   - Output stage never stalls, so sustained throughput is 1 write/cycle.
//   - A request with rd==0 is accepted, but gpr_wen stays 0 and the scoreboard is untouched.
//  Scoreboard: busy[NREG-1:1]
//   - Hazard = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (iss_wr & busy[rd]).
//   - iss_ready = ~hazard; x0 is never busy.
//   - Issue transfer with iss_wr & rd!=0 sets busy[rd].
//   - gpr_wen clears busy[gpr_rd] at the end of that cycle.
//   - Set and clear of the same index in one cycle: set wins. This is only reachable with forwarding.
//  Error flag
//   - Registered write-back with rd!=0 and busy[rd]==0 sets err_wb.
//   - err_wb holds until rst.
//  Reset mid-operation
//   - Pending grants and the output write are discarded.
//   - gpr_wen is 0 in the cycle after rst.
// CONFIGURATION
//  Macro YSYX_23060278_WB_FWD_EN
//   Defined:
//    - A source is treated as not busy when gpr_wen & gpr_rd==rs.
//    - fwd_hitN=1 and fwd_data=gpr_wdata in that cycle.
//    - Issue of the same rd in the clearing cycle is allowed.
//   Undefined:
//    - fwd_hit1/2=0 and fwd_data=0.
//    - The hazard holds until the cycle after gpr_wen.
// STRUCTURE
//  Package ysyx_23060278_pkg holds:
//   - XLEN and AW.
//   - typedef enum {REQ_ALU, REQ_LSU} wb_req_e.
//   - The wb_req_t struct {rd, data}.
//  Sub-module ysyx_23060278_scoreboard holds the busy vector, the hazard check and the forwarding compare.
//  The arbiter, output register and error flag stay in the top module.
// TESTING
//  1. ALU only: rd=5, data=0xDEADBEEF -> alu_ready same cycle;
//     next cycle gpr_wen=1, gpr_rd=5, gpr_wdata=0xDEADBEEF.
//  2. ALU and LSU valid together for 4 cycles after reset -> grants ALU, LSU, ALU, LSU;
//     loser's ready=0 and its payload is held.
//  3. Issue rd=7, then issue with rs1=7 -> iss_ready=0 until write-back of rd=7.
//     FWD_EN: ready in the gpr_wen cycle with fwd_hit1=1.
//     No FWD_EN: ready one cycle later.
//  4. Write-back with rd=0, data=0x1234 -> accepted, gpr_wen stays 0, err_wb stays 0.
//  5. Write-back to rd=9 with busy[9]=0 -> err_wb=1 next cycle; stays 1 until rst.
//  6. rst asserted while an LSU grant is pending -> next cycle gpr_wen=0;
//     all busy bits clear; a stalled issue becomes ready.

Source files
------------

// File: rtl/ysyx_23060278_pkg.sv
// Shared types and sizes for the NPC write-back arbiter and register scoreboard.
package ysyx_23060278_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } wb_req_e;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic logic rd_is_zero(input logic [AW-1:0] rd);
        return (rd == {AW{1'b0}});
    endfunction

endpackage

// File: rtl/ysyx_23060278_scoreboard.sv
// Pending-write scoreboard: busy vector, RAW/WAW issue hazard check and the
// write-port forwarding compare (enabled by macro YSYX_23060278_WB_FWD_EN).
module ysyx_23060278_scoreboard
    import ysyx_23060278_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic            iss_wr,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic            iss_use_rs1,
    input  logic            iss_use_rs2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            iss_ready,
    output logic            wb_busy,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data
);

`ifdef YSYX_23060278_WB_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic [NREG-1:1] busy_r;
    logic [NREG-1:1] busy_next_s;
    logic [NREG-1:0] busy_all_s;
    logic            hit_rd_s;
    logic            hazard_s;
    logic            set_s;

    // x0 is appended as a constant zero so any index can be looked up directly
    assign busy_all_s = {busy_r, 1'b0};

    // Compare issue operands against the write currently on the GPR port
    always_comb begin
        fwd_hit1 = FWD_ON & wb_en & (wb_rd == iss_rs1);
        fwd_hit2 = FWD_ON & wb_en & (wb_rd == iss_rs2);
        hit_rd_s = FWD_ON & wb_en & (wb_rd == iss_rd);
        if (FWD_ON) begin
            fwd_data = wb_data;
        end else begin
            fwd_data = {XLEN{1'b0}};
        end
    end

    // Hazard check; a forwarded register no longer counts as pending
    always_comb begin
        hazard_s  = (iss_use_rs1 & busy_all_s[iss_rs1] & ~fwd_hit1)
                  | (iss_use_rs2 & busy_all_s[iss_rs2] & ~fwd_hit2)
                  | (iss_wr      & busy_all_s[iss_rd]  & ~hit_rd_s);
        iss_ready = ~hazard_s;
        set_s     = iss_valid & ~hazard_s & iss_wr & ~rd_is_zero(iss_rd);
        wb_busy   = busy_all_s[wb_rd];
    end

    // Next busy vector: a new issue of the same index overrides the retiring write
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 1; i < NREG; i++) begin
            if (set_s && (iss_rd == AW'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (wb_en && (wb_rd == AW'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {(NREG-1){1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

endmodule

// File: rtl/ysyx_23060278_wb_arb.sv
// GPR write-back arbiter: round-robin ALU/LSU grant, registered write port,
// sticky error flag. Forwarding is enabled by macro YSYX_23060278_WB_FWD_EN.
module ysyx_23060278_wb_arb
    import ysyx_23060278_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic            iss_wr,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic            iss_use_rs1,
    input  logic            iss_use_rs2,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            gpr_wen,
    output logic [AW-1:0]   gpr_rd,
    output logic [XLEN-1:0] gpr_wdata,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data,
    output logic            err_wb
);

    wb_req_e last_grant_r;
    wb_req_t alu_req_s;
    wb_req_t lsu_req_s;
    wb_req_t win_s;
    logic    alu_grant_s;
    logic    lsu_grant_s;
    logic    xfer_s;
    logic    wr_s;
    logic    wb_busy_s;

    assign alu_req_s = '{rd: alu_rd, data: alu_data};
    assign lsu_req_s = '{rd: lsu_rd, data: lsu_data};

    // Round-robin grant; nothing is granted while reset is held so no request is lost
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (rst) begin
            alu_grant_s = 1'b0;
            lsu_grant_s = 1'b0;
        end else if (alu_valid && lsu_valid) begin
            alu_grant_s = (last_grant_r == REQ_LSU);
            lsu_grant_s = (last_grant_r == REQ_ALU);
        end else begin
            alu_grant_s = alu_valid;
            lsu_grant_s = lsu_valid;
        end
    end

    assign alu_ready = alu_grant_s;
    assign lsu_ready = lsu_grant_s;

    // Winner payload mux and write qualification (x0 writes are swallowed)
    always_comb begin
        if (lsu_grant_s) begin
            win_s = lsu_req_s;
        end else begin
            win_s = alu_req_s;
        end
        xfer_s = alu_grant_s | lsu_grant_s;
        wr_s   = xfer_s & ~rd_is_zero(win_s.rd);
    end

    // Grant history and registered GPR write port
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_LSU;
            gpr_wen      <= 1'b0;
            gpr_rd       <= {AW{1'b0}};
            gpr_wdata    <= {XLEN{1'b0}};
        end else begin
            gpr_wen <= wr_s;
            if (wr_s) begin
                gpr_rd    <= win_s.rd;
                gpr_wdata <= win_s.data;
            end else begin
                gpr_rd    <= gpr_rd;
                gpr_wdata <= gpr_wdata;
            end
            if (alu_grant_s) begin
                last_grant_r <= REQ_ALU;
            end else if (lsu_grant_s) begin
                last_grant_r <= REQ_LSU;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Sticky flag: a write retiring to a register nobody was waiting on
    always_ff @(posedge clk) begin
        if (rst) begin
            err_wb <= 1'b0;
        end else if (gpr_wen && !rd_is_zero(gpr_rd) && !wb_busy_s) begin
            err_wb <= 1'b1;
        end else begin
            err_wb <= err_wb;
        end
    end

    ysyx_23060278_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_wr      (iss_wr),
        .iss_rd      (iss_rd),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_use_rs1 (iss_use_rs1),
        .iss_use_rs2 (iss_use_rs2),
        .wb_en       (gpr_wen),
        .wb_rd       (gpr_rd),
        .wb_data     (gpr_wdata),
        .iss_ready   (iss_ready),
        .wb_busy     (wb_busy_s),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data    (fwd_data)
    );

endmodule

// File: tb/tb_ysyx_23060278_wb_arb.sv
// Bench for ysyx_23060278_wb_arb: per-cycle compare against a behavioural model
// plus directed scenarios with literal expectations.
module tb_ysyx_23060278_wb_arb;
    import ysyx_23060278_pkg::*;

`ifdef YSYX_23060278_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0, iss_wr = 1'b0, iss_use_rs1 = 1'b0, iss_use_rs2 = 1'b0;
    logic [4:0]  iss_rd = 5'd0, iss_rs1 = 5'd0, iss_rs2 = 5'd0;
    logic        iss_ready;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd = 5'd0, lsu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0, lsu_data = 32'd0;
    logic        gpr_wen;
    logic [4:0]  gpr_rd;
    logic [31:0] gpr_wdata;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data;
    logic        err_wb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    wb_req_t alu_q[$];
    wb_req_t lsu_q[$];

    ysyx_23060278_wb_arb dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wr(iss_wr), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data), .err_wb(err_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]   m_busy  = 32'd0;  // set of registers with a write outstanding
    bit          m_last  = 1'b1;   // 1: LSU was granted last
    bit          m_wen   = 1'b0;
    logic [4:0]  m_rd    = 5'd0;
    logic [31:0] m_wdata = 32'd0;
    bit          m_err   = 1'b0;

    function automatic bit pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(FWD && m_wen && (m_rd == r));
    endfunction

    function automatic bit e_iss_ready();
        return !((iss_use_rs1 && pending(iss_rs1)) || (iss_use_rs2 && pending(iss_rs2)) ||
                 (iss_wr && pending(iss_rd)));
    endfunction

    function automatic bit e_alu_ready();
        return !rst && alu_valid && (!lsu_valid || m_last);
    endfunction

    function automatic bit e_lsu_ready();
        return !rst && lsu_valid && (!alu_valid || !m_last);
    endfunction

    function automatic logic [4:0] won_rd();
        return e_lsu_ready() ? lsu_rd : alu_rd;
    endfunction

    function automatic logic [31:0] won_data();
        return e_lsu_ready() ? lsu_data : alu_data;
    endfunction

    function automatic bit [31:0] next_busy();
        bit [31:0] b;
        b = m_busy;
        if (m_wen) b[m_rd] = 1'b0;
        if (iss_valid && e_iss_ready() && iss_wr && (iss_rd != 5'd0)) b[iss_rd] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 32'd0; m_last <= 1'b1; m_wen <= 1'b0;
            m_rd <= 5'd0; m_wdata <= 32'd0; m_err <= 1'b0;
        end else begin
            m_err  <= m_err || (m_wen && !m_busy[m_rd]);
            m_busy <= next_busy();
            m_wen  <= (e_alu_ready() || e_lsu_ready()) && (won_rd() != 5'd0);
            if ((e_alu_ready() || e_lsu_ready()) && (won_rd() != 5'd0)) begin
                m_rd    <= won_rd();
                m_wdata <= won_data();
            end
            if (e_alu_ready()) m_last <= 1'b0;
            else if (e_lsu_ready()) m_last <= 1'b1;
        end
    end

    // Every-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gpr_wen", gpr_wen, m_wen);
            if (m_wen) begin
                chk("gpr_rd", gpr_rd, m_rd);
                chk("gpr_wdata", gpr_wdata, m_wdata);
            end
            chk("err_wb", err_wb, m_err);
            chk("iss_ready", iss_ready, e_iss_ready());
            chk("alu_ready", alu_ready, e_alu_ready());
            chk("lsu_ready", lsu_ready, e_lsu_ready());
            chk("fwd_hit1", fwd_hit1, FWD && m_wen && (m_rd == iss_rs1));
            chk("fwd_hit2", fwd_hit2, FWD && m_wen && (m_rd == iss_rs2));
            if (!FWD) chk("fwd_data", fwd_data, 32'd0);
            else if (m_wen && ((m_rd == iss_rs1) || (m_rd == iss_rs2)))
                chk("fwd_data", fwd_data, m_wdata);
        end
    end

    // Write-back requesters: hold valid and payload until the handshake completes
    initial begin
        bit a_fire, l_fire;
        forever begin
            @(negedge clk);
            a_fire = alu_valid && alu_ready;
            l_fire = lsu_valid && lsu_ready;
            @(posedge clk);
            #1;
            if (a_fire && alu_q.size() > 0) void'(alu_q.pop_front());
            if (l_fire && lsu_q.size() > 0) void'(lsu_q.pop_front());
            alu_valid = (alu_q.size() > 0);
            if (alu_q.size() > 0) begin alu_rd = alu_q[0].rd; alu_data = alu_q[0].data; end
            lsu_valid = (lsu_q.size() > 0);
            if (lsu_q.size() > 0) begin lsu_rd = lsu_q[0].rd; lsu_data = lsu_q[0].data; end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alu_q.delete();
        lsu_q.delete();
        iss_valid = 1'b0; iss_wr = 1'b0; iss_use_rs1 = 1'b0; iss_use_rs2 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        bit ok;
        ok = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd; iss_use_rs1 = 1'b0; iss_use_rs2 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (iss_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("issue");
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
    endtask

    task automatic wait_alu_fire(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (alu_valid && alu_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        bit ok, first_ready, hit;
        int w, r, n;
        logic [31:0] gcode, wcode;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_wen", gpr_wen, 32'd0);
        chk("rst_rd", gpr_rd, 32'd0);
        chk("rst_wdata", gpr_wdata, 32'd0);
        chk("rst_err", err_wb, 32'd0);
        tick();

        // 1: single ALU write-back
        issue_rd(5'd5);
        alu_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (alu_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("t1_valid");
        chk("t1_alu_ready", alu_ready, 32'd1);
        @(negedge clk);
        chk("t1_wen", gpr_wen, 32'd1);
        chk("t1_rd", gpr_rd, 32'd5);
        chk("t1_wdata", gpr_wdata, 32'hDEAD_BEEF);
        tick();

        // 2: both requesters valid together after reset
        do_reset();
        issue_rd(5'd1); issue_rd(5'd2); issue_rd(5'd3); issue_rd(5'd4);
        alu_q.push_back('{rd: 5'd1, data: 32'hA000_0001});
        alu_q.push_back('{rd: 5'd2, data: 32'hA000_0002});
        lsu_q.push_back('{rd: 5'd3, data: 32'hB000_0003});
        lsu_q.push_back('{rd: 5'd4, data: 32'hB000_0004});
        gcode = 32'd0; wcode = 32'd0; n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (alu_valid && alu_ready) gcode = {gcode[30:0], 1'b0};
            if (lsu_valid && lsu_ready) gcode = {gcode[30:0], 1'b1};
            if (gpr_wen) begin wcode = (wcode << 5) | 32'(gpr_rd); n++; end
        end
        if (n < 4) timeout("t2_writes");
        chk("t2_grants", gcode, 32'b0101);
        chk("t2_order", wcode, 32'({5'd1, 5'd3, 5'd2, 5'd4}));
        chk("t2_no_err", err_wb, 32'd0);
        tick();

        // 3: RAW stall released by the write-back of rd=7
        do_reset();
        issue_rd(5'd7);
        iss_valid = 1'b1; iss_wr = 1'b0; iss_rs1 = 5'd7; iss_use_rs1 = 1'b1;
        alu_q.push_back('{rd: 5'd7, data: 32'h0000_0777});
        w = -100; r = -1; hit = 1'b0; first_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) first_ready = iss_ready;
            if (gpr_wen && (gpr_rd == 5'd7) && (w < 0)) w = cyc;
            if (iss_ready) begin r = cyc; hit = fwd_hit1; break; end
        end
        if (r < 0) timeout("t3_ready");
        chk("t3_first_stall", first_ready, 32'd0);
        chk("t3_gap", r - w, FWD ? 32'd0 : 32'd1);
        chk("t3_fwd_hit1", hit, FWD ? 32'd1 : 32'd0);
        tick();
        iss_valid = 1'b0; iss_use_rs1 = 1'b0;

        // 4: write-back to x0 is accepted but dropped
        do_reset();
        alu_q.push_back('{rd: 5'd0, data: 32'h0000_1234});
        wait_alu_fire("t4_fire");
        @(negedge clk);
        chk("t4_wen", gpr_wen, 32'd0);
        @(negedge clk);
        chk("t4_err", err_wb, 32'd0);
        tick();

        // 5: write-back to a non-busy register raises the sticky error
        alu_q.push_back('{rd: 5'd9, data: 32'h0000_0099});
        wait_alu_fire("t5_fire");
        @(negedge clk);
        chk("t5_wen", gpr_wen, 32'd1);
        chk("t5_err_before", err_wb, 32'd0);
        @(negedge clk);
        chk("t5_err_set", err_wb, 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", err_wb, 32'd1);
        tick();

        // 6: reset while an LSU grant is pending and an issue is stalled
        issue_rd(5'd11);
        iss_valid = 1'b1; iss_wr = 1'b0; iss_rs2 = 5'd11; iss_use_rs2 = 1'b1;
        alu_q.push_back('{rd: 5'd12, data: 32'hC000_000C});
        lsu_q.push_back('{rd: 5'd13, data: 32'hD000_000D});
        wait_alu_fire("t6_fire");
        chk("t6_lsu_pending", lsu_ready, 32'd0);
        chk("t6_stalled", iss_ready, 32'd0);
        tick();
        rst = 1'b1;
        alu_q.delete();
        lsu_q.delete();
        @(negedge clk);
        chk("t6_wen_in_rst", gpr_wen, 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wen_after", gpr_wen, 32'd0);
        chk("t6_ready_after", iss_ready, 32'd1);
        chk("t6_err_cleared", err_wb, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_write", gpr_wen, 32'd0);
        end
        tick();
        iss_valid = 1'b0; iss_use_rs2 = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
